pixel_stream_tx: RTL
====================

# pixel_stream_tx

- Frame-reader transmitter on the input side of the image-processing core.
- Sources pixels for the core's AXI-stream pixel input (data/valid/last/keep, with ready back-pressure).
- After a start pulse, walks a ROWS×COLS frame in a synchronous read-port pixel memory in raster order and emits one 8-bit pixel per beat.
- Asserts last on the final pixel of every line and sustains 1 pixel/cycle while ready stays high.

## Interface
Parameters:
- DATA_W, 8, pixel width
- COLS, 1024, pixels per line (≥2)
- ROWS, 1024, lines per frame (≥1)
- ADDR_W, 20, memory address width; must satisfy 2^ADDR_W ≥ ROWS·COLS

Ports:
- clk  in  1  sole clock; one clock; reset is synchronous and active-high
- rst  in  1  synchronous active-high reset
- start  in  1  one-cycle request to send a frame; ignored while busy
- busy  out  1  high from the cycle after an accepted start until done
- done  out  1  one-cycle pulse after the frame's final beat handshakes
- mem_rd_en  out  1  read strobe
- mem_addr  out  ADDR_W  read address, row·COLS+col
- mem_rd_data  in  DATA_W  valid exactly one cycle after mem_rd_en
- axi_data  out  DATA_W  pixel
- axi_valid  out  1  beat valid
- axi_ready  in  1  downstream accept (core's gauss ready)
- axi_last  out  1  end-of-line marker
- axi_keep  out  1  constant 1 while valid, else 0

## Operation
- FSM states:
  - IDLE: start → RUN; address counter = 0.
  - RUN: issue reads while credit allows; after the read of address ROWS·COLS−1 → DRAIN.
  - DRAIN: wait for the buffer to empty and the final beat to handshake → IDLE, pulse done.
- Credit rule: issue a read only if (buffer occupancy + reads in flight) < 2. Never overflow; never drop a returned word.
- Buffer: 2-entry skid FIFO. Each entry holds {data, last}.
  - last = (col == COLS−1), computed at issue time and pipelined alongside the read.
- Handshake: a beat transfers when axi_valid && axi_ready.
  - Once axi_valid rises, axi_data, axi_last and axi_valid hold stable until transfer.
  - axi_valid does not depend combinationally on axi_ready.
- Counters: col wraps COLS−1→0 and increments row; row stops at ROWS−1. Address is a separate linear counter; no multiplier.
- Simultaneous push and pop on the buffer keeps occupancy unchanged.
- start during RUN/DRAIN is ignored. start in the same cycle as done's IDLE return is accepted (back-to-back frames).
- Reset mid-frame: immediately IDLE, buffer flushed, all outputs at reset values. No partial last is emitted.
- Reset values: busy=0, done=0, mem_rd_en=0, mem_addr=0, axi_valid=0, axi_last=0, axi_keep=0, axi_data=0.

## Timing
- start sampled high at edge N:
  - busy and mem_rd_en (addr 0) high in cycle N+1.
  - Data captured at edge N+2; axi_valid high in cycle N+3 (first-beat latency 3).
- With axi_ready held high: one beat per cycle, no bubbles. Frame occupies ROWS·COLS consecutive beat cycles.
- axi_ready low for k cycles: at most 2 reads outstanding. Output resumes in the cycle ready returns, with no lost or duplicated pixel.
- done is high the cycle after the final transfer; busy falls in that same cycle.

## Configuration
- PIXEL_STREAM_TX_SOF_EN
  - Defined: adds output port axi_user (1 bit). It is high only on the first beat of each frame (row 0, col 0), pipelined with the data like last; reset 0.
  - Undefined: the port and its pipeline bit are absent. Behaviour is otherwise identical.

## Structure
- Shared package pixel_stream_pkg: FSM state enum (IDLE/RUN/DRAIN), default DATA_W/COLS/ROWS constants, and the {data, last[, user]} beat struct width.
- One sub-module: pixel_stream_skid_buf, a 2-entry valid/ready FIFO with registered outputs. The top holds the FSM, counters and credit logic.

## Test plan
- COLS=4, ROWS=2, ready=1, mem[a]=a: start at N → axi_valid at N+3; data 0..7 on consecutive cycles; last on beats 3 and 7; done at N+11.
- Same config, ready low on beat 2 for 5 cycles: data holds 2 through the stall; at most 2 reads outstanding; output resumes at 2,3,…,7 with no gaps or duplicates.
- Random ready (50%), COLS=16, ROWS=8: the 128 received bytes equal mem[0..127] in order; last count = 8; valid never drops without a handshake.
- start pulsed during RUN: ignored, exactly one frame sent. start on the done cycle: a second frame begins with addr 0 at the next cycle.
- rst asserted at beat 5: next cycle all outputs 0 and busy=0. A subsequent start restarts from addr 0 and emits a full frame.
- PIXEL_STREAM_TX_SOF_EN defined: axi_user=1 only on beat 0 of each frame, across two back-to-back frames.

Source files
------------

// File: rtl/pixel_stream_pkg.sv
// Shared types and defaults for the pixel stream transmitter.
// Defining PIXEL_STREAM_TX_SOF_EN adds a start-of-frame sideband bit to each beat.
package pixel_stream_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_COLS   = 1024;
  localparam int DEF_ROWS   = 1024;

  typedef struct packed {
    logic last;
`ifdef PIXEL_STREAM_TX_SOF_EN
    logic user;
`endif
  } side_t;

  localparam int SIDE_W = $bits(side_t);

  function automatic int beat_w(input int data_w);
    return data_w + SIDE_W;
  endfunction

endpackage

// File: rtl/pixel_stream_skid_buf.sv
// Two-entry valid/ready FIFO: a registered output stage backed by one skid slot.
module pixel_stream_skid_buf #(
  parameter int W = 9
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic [1:0]   count
);

  logic         skid_vld;
  logic [W-1:0] skid_data;
  logic         pop;
  logic         load_out;

  assign pop      = out_valid && out_ready;
  assign load_out = !out_valid || pop;
  assign count    = {1'b0, out_valid} + {1'b0, skid_vld};

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      skid_vld  <= 1'b0;
    end else if (load_out) begin
      out_valid <= skid_vld || in_valid;
      skid_vld  <= skid_vld && in_valid;
    end else begin
      skid_vld  <= skid_vld || in_valid;
    end
  end

  // Output register is cleared on reset so the stream presents zeros when idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_data <= '0;
    end else if (load_out && (skid_vld || in_valid)) begin
      out_data <= skid_vld ? skid_data : in_data;
    end
  end

  always_ff @(posedge clk) begin
    if ((load_out && skid_vld && in_valid) || (!load_out && in_valid)) begin
      skid_data <= in_data;
    end
  end

endmodule

// File: rtl/pixel_stream_tx.sv
// Frame reader: walks a ROWS x COLS pixel memory in raster order onto an AXI-stream.
// Defining PIXEL_STREAM_TX_SOF_EN adds axi_user marking the first beat of each frame.
module pixel_stream_tx
  import pixel_stream_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int COLS   = DEF_COLS,
  parameter int ROWS   = DEF_ROWS,
  parameter int ADDR_W = 20
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rd_data,
  output logic [DATA_W-1:0] axi_data,
  output logic              axi_valid,
  input  logic              axi_ready,
  output logic              axi_last,
  output logic              axi_keep
`ifdef PIXEL_STREAM_TX_SOF_EN
  ,
  output logic              axi_user
`endif
);

  localparam int COL_W  = $clog2(COLS);
  localparam int ROW_W  = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int BEAT_W = beat_w(DATA_W);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(COLS - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROWS - 1);

  state_t            state;
  state_t            state_nxt;
  logic [COL_W-1:0]  col;
  logic [ROW_W-1:0]  row;
  logic [ADDR_W-1:0] addr;
  logic              rd_en;
  logic              done_nxt;
  logic              final_issue;
  logic              credit_ok;
  logic [1:0]        credit_used;
  logic [1:0]        buf_cnt;
  logic              pop;
  side_t             side_issue;
  logic              vld_p0;
  side_t             side_p0;
  logic [BEAT_W-1:0] beat_out;
  side_t             side_out;

  assign pop         = axi_valid && axi_ready;
  assign final_issue = (row == ROW_LAST) && (col == COL_LAST);
  // A pop this cycle frees a slot, which is what keeps the stream gap-free.
  assign credit_used = buf_cnt - {1'b0, pop} + {1'b0, vld_p0};
  assign credit_ok   = credit_used < 2'd2;

  assign side_issue.last = (col == COL_LAST);
`ifdef PIXEL_STREAM_TX_SOF_EN
  assign side_issue.user = (row == '0) && (col == '0);
`endif

  always_comb begin
    state_nxt = state;
    rd_en     = 1'b0;
    done_nxt  = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = RUN;
      end
      RUN: begin
        if (credit_ok) begin
          rd_en = 1'b1;
          if (final_issue) state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (!vld_p0 && (buf_cnt == 2'd1) && pop) begin
          state_nxt = IDLE;
          done_nxt  = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      done  <= done_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || (state == IDLE && start)) begin
      addr <= '0;
      col  <= '0;
      row  <= '0;
    end else if (rd_en) begin
      addr <= addr + 1'b1;
      if (col == COL_LAST) begin
        col <= '0;
        if (row != ROW_LAST) row <= row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

  // ---- stage p0: read in flight, sideband travels with it ----
  always_ff @(posedge clk) begin
    if (rst) vld_p0 <= 1'b0;
    else     vld_p0 <= rd_en;
    side_p0 <= side_issue;
  end

  // ---- stage p1: returned word captured into the skid buffer ----
  pixel_stream_skid_buf #(
    .W (BEAT_W)
  ) u_buf (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (vld_p0),
    .in_data   ({mem_rd_data, side_p0}),
    .out_valid (axi_valid),
    .out_ready (axi_ready),
    .out_data  (beat_out),
    .count     (buf_cnt)
  );

  assign side_out  = side_t'(beat_out[SIDE_W-1:0]);
  assign axi_data  = beat_out[BEAT_W-1 -: DATA_W];
  assign axi_last  = axi_valid & side_out.last;
  assign axi_keep  = axi_valid;
`ifdef PIXEL_STREAM_TX_SOF_EN
  assign axi_user  = axi_valid & side_out.user;
`endif
  assign busy      = (state != IDLE);
  assign mem_rd_en = rd_en;
  assign mem_addr  = addr;

endmodule
